// File: rtl/logip_pkg.sv
// Shared types and widths for the logic-analyzer capture controller.
// The byte-swap helper converts the transmitter's command byte order into count values.
package logip_pkg;

   localparam int CMD_WIDTH = 32;
   localparam int CNT_WIDTH = CMD_WIDTH / 2;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      READ,
      RD_WAIT,
      TX_WAIT
   } states_t;

   // Counts arrive over the serial link with their bytes in swapped order.
   function automatic logic [CNT_WIDTH-1:0] swapBytes(input logic [CNT_WIDTH-1:0] half);
      return {half[7:0], half[15:8]};
   endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample-RAM and transmitter handshake bundle between the capture controller and its peers.
interface capture_ctrl_if #(
   parameter int DEPTH = 5
);

   logic             we;
   logic             re;
   logic [DEPTH-1:0] addr;
   logic             tx_rdy;
   logic             tx_stb;
   logic             tx_sel;

   modport master (
      output we,
      output re,
      output addr,
      output tx_stb,
      output tx_sel,
      input  tx_rdy
   );

   modport slave (
      input  we,
      input  re,
      input  addr,
      input  tx_stb,
      input  tx_sel,
      output tx_rdy
   );

endinterface

// File: rtl/capture_ctrl_sat_cnt.sv
// Saturating up-counter; tracks how much of the circular sample RAM holds real data.
module sat_cnt #(
   parameter int               WIDTH = 6,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/capture_ctrl.sv
// Logic-analyzer capture controller: circular sample recording, post-trigger delay,
// then newest-first readout of the captured window to the UART transmitter.
module capture_ctrl
   import logip_pkg::*;
#(
   parameter int DEPTH     = 5,
   parameter int GRAN_LOG2 = 2,
   parameter int RD_LAT    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 set_cnt_i,
   input  logic [CMD_WIDTH-1:0] cmd_i,
   input  logic                 run_i,
   input  logic                 abort_i,
   input  logic                 stb_i,
   capture_ctrl_if.master       bus,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int             TGT_W    = CNT_WIDTH + GRAN_LOG2;
   localparam logic [2:0]     LAT_END  = 3'(RD_LAT);
   localparam logic [DEPTH:0] FILL_MAX = {1'b1, {DEPTH{1'b0}}};

   states_t              state_q,   state_d;
   logic [TGT_W-1:0]     cnt_q,     cnt_d;
   logic [DEPTH-1:0]     ptr_q,     ptr_d;
   logic [TGT_W-1:0]     limit_q,   limit_d;
   logic [CNT_WIDTH-1:0] rd_cnt_q,  rd_cnt_d;
   logic [CNT_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
   logic [2:0]           lat_q,     lat_d;
   logic                 tx_first_q, tx_first_d;

   logic             weInt;
   logic             reInt;
   logic             txStbInt;
   logic             doneInt;
   logic [DEPTH:0]   fill;
   logic [TGT_W-1:0] dlyTgt;
   logic [TGT_W-1:0] rdTgt;
   logic [TGT_W-1:0] fillWide;

   assign dlyTgt   = TGT_W'(dly_cnt_q) << GRAN_LOG2;
   assign rdTgt    = TGT_W'(rd_cnt_q) << GRAN_LOG2;
   assign fillWide = TGT_W'(fill);

   sat_cnt #(
      .WIDTH (DEPTH + 1),
      .MAX   (FILL_MAX)
   ) u_fill (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (weInt),
      .cnt_o (fill)
   );

   // Abort is checked first in every busy state so it beats writes, reads and completion.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      limit_d    = limit_q;
      rd_cnt_d   = rd_cnt_q;
      dly_cnt_d  = dly_cnt_q;
      lat_d      = lat_q;
      tx_first_d = tx_first_q;
      weInt      = 1'b0;
      reInt      = 1'b0;
      txStbInt   = 1'b0;
      doneInt    = 1'b0;

      case (state_q)
         IDLE: begin
            if (set_cnt_i) begin
               rd_cnt_d  = swapBytes(cmd_i[31:16]);
               dly_cnt_d = swapBytes(cmd_i[15:0]);
            end
            if (stb_i) begin
               weInt = 1'b1;
               ptr_d = ptr_q + DEPTH'(1);
            end
            if (run_i) begin
               state_d = DELAY;
               cnt_d   = '0;
            end
         end

         DELAY: begin
            if (abort_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == dlyTgt) begin
               state_d = READ;
               cnt_d   = '0;
               ptr_d   = ptr_q - DEPTH'(1);
               limit_d = (rdTgt < fillWide) ? rdTgt : fillWide;
            end else if (stb_i) begin
               weInt = 1'b1;
               ptr_d = ptr_q + DEPTH'(1);
               cnt_d = cnt_q + TGT_W'(1);
            end
         end

         READ: begin
            if (abort_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == limit_q) begin
               state_d = IDLE;
               cnt_d   = '0;
               doneInt = 1'b1;
            end else begin
               reInt   = 1'b1;
               state_d = RD_WAIT;
               lat_d   = 3'd1;
            end
         end

         // RAM data lands RD_LAT cycles after re, exactly when the transmitter is strobed.
         RD_WAIT: begin
            if (abort_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (lat_q == LAT_END) begin
               txStbInt   = 1'b1;
               ptr_d      = ptr_q - DEPTH'(1);
               cnt_d      = cnt_q + TGT_W'(1);
               state_d    = TX_WAIT;
               tx_first_d = 1'b1;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end

         TX_WAIT: begin
            if (abort_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (tx_first_q) begin
               tx_first_d = 1'b0;
            end else if (bus.tx_rdy) begin
               state_d = READ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= '0;
         limit_q    <= '0;
         rd_cnt_q   <= CNT_WIDTH'(1);
         dly_cnt_q  <= CNT_WIDTH'(1);
         lat_q      <= '0;
         tx_first_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         limit_q    <= limit_d;
         rd_cnt_q   <= rd_cnt_d;
         dly_cnt_q  <= dly_cnt_d;
         lat_q      <= lat_d;
         tx_first_q <= tx_first_d;
      end
   end

   // Strobes are masked while reset is held so a live stb_i cannot leak through.
   assign bus.we     = weInt & ~rst_i;
   assign bus.re     = reInt & ~rst_i;
   assign bus.tx_stb = txStbInt & ~rst_i;
   assign bus.addr   = ptr_q;
   assign bus.tx_sel = (state_q != IDLE);
   assign busy_o     = (state_q != IDLE);
   assign done_o     = doneInt & ~rst_i;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: readout events are queued as stimulus is issued
// and a negedge monitor pops and compares them whenever the DUT strobes tx or done.
module tb_capture_ctrl;
   import logip_pkg::*;

   localparam int DEPTH = 5;
   localparam int GRAN  = 2;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam logic [31:0] DONE_EV = 32'h100;

   logic                 clk    = 1'b0;
   logic                 rst    = 1'b1;
   logic                 setCnt = 1'b0;
   logic                 run    = 1'b0;
   logic                 abort  = 1'b0;
   logic                 stb    = 1'b0;
   logic                 txRdy  = 1'b1;
   logic [CMD_WIDTH-1:0] cmd    = '0;
   logic                 sel    = 1'b0;
   logic                 busyA, doneA, busyB, doneB;

   capture_ctrl_if #(.DEPTH(DEPTH)) busA();
   capture_ctrl_if #(.DEPTH(DEPTH)) busB();

   assign busA.tx_rdy = txRdy;
   assign busB.tx_rdy = txRdy;

   capture_ctrl #(.DEPTH(DEPTH), .GRAN_LOG2(GRAN), .RD_LAT(LAT_A)) dutA (
      .clk_i(clk), .rst_i(rst), .set_cnt_i(setCnt), .cmd_i(cmd), .run_i(run),
      .abort_i(abort), .stb_i(stb), .bus(busA), .busy_o(busyA), .done_o(doneA)
   );

   capture_ctrl #(.DEPTH(DEPTH), .GRAN_LOG2(GRAN), .RD_LAT(LAT_B)) dutB (
      .clk_i(clk), .rst_i(rst), .set_cnt_i(setCnt), .cmd_i(cmd), .run_i(run),
      .abort_i(abort), .stb_i(stb), .bus(busB), .busy_o(busyB), .done_o(doneB)
   );

   always #5 clk = ~clk;

   logic             mWe, mRe, mTxStb, mTxSel, mBusy, mDone;
   logic [DEPTH-1:0] mAddr;

   always_comb begin
      if (sel) begin
         mWe = busB.we; mRe = busB.re; mTxStb = busB.tx_stb; mTxSel = busB.tx_sel;
         mBusy = busyB; mDone = doneB; mAddr = busB.addr;
      end else begin
         mWe = busA.we; mRe = busA.re; mTxStb = busA.tx_stb; mTxSel = busA.tx_sel;
         mBusy = busyA; mDone = doneA; mAddr = busA.addr;
      end
   end

   logic [31:0] expQ[$];
   int checkCount  = 0;
   int passCount   = 0;
   int cycleCount  = 0;
   int lastReCycle = 0;
   int weCount     = 0;
   int reCount     = 0;
   int txCount     = 0;
   logic             snapWe, snapBusy;
   logic [DEPTH-1:0] snapAddr;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
   endtask

   always @(posedge clk) cycleCount++;

   // Monitor: every tx_stb_o or done_o must match the head of the expectation queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (mWe) weCount++;
         if (mRe) begin
            reCount++;
            lastReCycle = cycleCount;
         end
         if (mTxStb) begin
            txCount++;
            checkOutput("re_o to tx_stb_o spacing", 32'(cycleCount - lastReCycle), sel ? LAT_B : LAT_A);
         end
         if (mTxStb || mDone) begin
            if (expQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpected readout event: actual %0d, required none", mDone ? DONE_EV : 32'(mAddr));
            end else begin
               checkOutput("readout event", mDone ? DONE_EV : 32'(mAddr), expQ.pop_front());
            end
         end
      end
   end

   task automatic applyStimulus(input logic s, input logic [31:0] c, input logic r, input logic a, input logic b);
      setCnt = s; cmd = c; run = r; abort = a; stb = b;
      @(negedge clk);
      snapWe = mWe; snapAddr = mAddr; snapBusy = mBusy;
      @(posedge clk); #1;
      setCnt = 1'b0; run = 1'b0; abort = 1'b0; stb = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
   endtask

   task automatic stbBurst(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1);
   endtask

   task automatic doReset();
      stb = 1'b1;
      rst = 1'b1;
      #1;
      checkOutput("outputs under reset", {mWe, mRe, 27'(mAddr), mTxStb, mTxSel, mBusy, mDone}, 0);
      @(posedge clk); #1;
      rst = 1'b0; stb = 1'b0;
      expQ.delete();
      weCount = 0; reCount = 0; txCount = 0;
   endtask

   task automatic waitDrain(input string name, input int bound);
      for (int i = 0; i < bound && expQ.size() != 0; i++) idleCycles(1);
      idleCycles(6);
      checkOutput(name, expQ.size(), 0);
   endtask

   task automatic waitTx(input int n, input int bound);
      for (int i = 0; i < bound && txCount < n; i++) idleCycles(1);
      checkOutput("tx_stb_o count reached", txCount, n);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      @(posedge clk); #1;

      // Long fill, dly_cnt=1, rd_cnt=2: eight samples newest first.
      sel = 1'b0;
      doReset();
      stbBurst(40);
      applyStimulus(1, 32'h0200_0100, 0, 0, 0);
      for (int i = 0; i < 8; i++) expQ.push_back(32'(11 - i));
      expQ.push_back(DONE_EV);
      applyStimulus(0, 0, 1, 0, 0);
      stbBurst(4);
      waitDrain("full readout drained", 200);
      checkOutput("total writes", weCount, 44);

      // Short fill limits readout, then read pointer wraps 0 -> 31.
      doReset();
      stbBurst(3);
      applyStimulus(1, 32'h0800_0000, 0, 0, 0);
      expQ.push_back(2); expQ.push_back(1); expQ.push_back(0); expQ.push_back(DONE_EV);
      applyStimulus(0, 0, 1, 0, 0);
      waitDrain("fill-limited readout drained", 100);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("we_o after wrap", snapWe, 1);
      checkOutput("write addr after read wrap", snapAddr, 31);

      // Three-cycle read latency and transmitter back-pressure.
      sel = 1'b1;
      doReset();
      stbBurst(6);
      applyStimulus(1, 32'h0100_0000, 0, 0, 0);
      expQ.push_back(5); expQ.push_back(4); expQ.push_back(3); expQ.push_back(2);
      expQ.push_back(DONE_EV);
      txRdy = 1'b0;
      applyStimulus(0, 0, 1, 0, 0);
      waitTx(1, 50);
      idleCycles(20);
      checkOutput("re_o count while tx_rdy_i low", reCount, 1);
      txRdy = 1'b1;
      waitDrain("latency-3 readout drained", 100);

      // Abort during TX_WAIT after two samples.
      sel = 1'b0;
      doReset();
      stbBurst(40);
      applyStimulus(1, 32'h0200_0100, 0, 0, 0);
      expQ.push_back(11); expQ.push_back(10);
      applyStimulus(0, 0, 1, 0, 0);
      stbBurst(4);
      waitTx(2, 100);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("busy_o after abort", mBusy, 0);
      idleCycles(20);
      checkOutput("tx_stb_o count after abort", txCount, 2);
      checkOutput("queue after abort", expQ.size(), 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("we_o after abort", snapWe, 1);
      checkOutput("write addr after abort", snapAddr, 9);

      // Count load ignored while busy, accepted in IDLE.
      doReset();
      stbBurst(8);
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 32'h0400_0200, 0, 0, 0);
      checkOutput("busy_o during DELAY", snapBusy, 1);
      for (int i = 0; i < 4; i++) expQ.push_back(32'(11 - i));
      expQ.push_back(DONE_EV);
      stbBurst(4);
      waitDrain("default-count readout drained", 100);
      applyStimulus(1, 32'h0400_0200, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0);
      stbBurst(7);
      idleCycles(3);
      checkOutput("busy_o in DELAY after 7 samples", mBusy, 1);
      for (int i = 0; i < 16; i++) expQ.push_back(32'((14 - i) & 31));
      expQ.push_back(DONE_EV);
      stbBurst(1);
      waitDrain("loaded-count readout drained", 300);

      // Reset mid-DELAY, then defaults again; fill=0 and rd_cnt=0 corner cases.
      doReset();
      applyStimulus(1, 32'h0400_0200, 0, 0, 0);
      stbBurst(5);
      applyStimulus(0, 0, 1, 0, 0);
      stbBurst(2);
      doReset();
      expQ.push_back(3); expQ.push_back(2); expQ.push_back(1); expQ.push_back(0);
      expQ.push_back(DONE_EV);
      applyStimulus(0, 0, 1, 0, 0);
      stbBurst(4);
      waitDrain("post-reset readout drained", 100);

      doReset();
      applyStimulus(1, 32'h0100_0000, 0, 0, 0);
      expQ.push_back(DONE_EV);
      applyStimulus(0, 0, 1, 0, 0);
      waitDrain("empty-fill done drained", 20);
      checkOutput("tx_stb_o with empty fill", txCount, 0);

      stbBurst(2);
      applyStimulus(1, 32'h0000_0000, 0, 0, 0);
      expQ.push_back(DONE_EV);
      applyStimulus(0, 0, 1, 0, 0);
      waitDrain("zero rd_cnt done drained", 20);
      checkOutput("tx_stb_o with rd_cnt 0", txCount, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
